card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
- Upstream of the card-to-7-segment decoders: sequences one baccarat hand and holds the six 4-bit card codes those decoders display.
- A free-running 1..13 counter is sampled on each operator `step` strobe.
- An FSM deals the four initial cards alternately to player and dealer, applies the third-card rules, and reports scores and the winner.
- Card encoding: 0 = no card (blank), 1 = A, 2..10 = pips, 11 = J, 12 = Q, 13 = K.

Parameters:
None.

Ports:
clk  input  1  system clock; all state on rising edge
resetb  input  1  asynchronous active-low reset
step  input  1  one-cycle deal strobe, already debounced and synchronised upstream
new_hand  input  1  one-cycle synchronous restart strobe
pcard1  output  4  player card 1 code
pcard2  output  4  player card 2 code
pcard3  output  4  player card 3 code
dcard1  output  4  dealer card 1 code
dcard2  output  4  dealer card 2 code
dcard3  output  4  dealer card 3 code
pscore  output  4  player score, 0..9
dscore  output  4  dealer score, 0..9
done  output  1  hand complete
player_win  output  1  player score >= dealer score, valid only while done
dealer_win  output  1  dealer score >= player score, valid only while done

Behaviour:
- Reset (resetb=0, asynchronous):
  - all card registers 0; pscore = dscore = 0.
  - done, player_win, dealer_win = 0.
  - FSM in DEAL_P1; counter = 1.
- Counter:
  - increments every clk edge, wraps 13 -> 1, never 0, never stalls.
  - After reset release, value during cycle n is 1 + (n mod 13), with n = edges since release and cycle 0 = first cycle after release.
- Dealing: a card register takes the counter value present in the cycle where step=1 and the FSM is in a DEAL state. Loaded at that edge, visible the next cycle.
- Card value: code 1..9 -> 1..9; code 10..13 -> 0; code 0 -> 0.
- Scores: (sum of the hand's three card values) mod 10, combinational from the card registers.
- FSM states and transitions:
  - DEAL_P1 -step-> DEAL_D1 -step-> DEAL_P2 -step-> DEAL_D2 -step-> CHK1.
  - CHK1 (one cycle, no step needed):
    - pscore or dscore in {8,9} -> DONE (natural).
    - else pscore <= 5 -> DEAL_P3.
    - else dscore <= 5 -> DEAL_D3.
    - else -> DONE.
  - DEAL_P3 -step-> CHK2.
  - CHK2 (one cycle): with v = value of pcard3, dealer draws (-> DEAL_D3) when:
    - dscore 0..2;
    - 3 and v != 8;
    - 4 and v in 2..7;
    - 5 and v in 4..7;
    - 6 and v in 6..7.
    - Otherwise -> DONE.
  - DEAL_D3 -step-> DONE.
  - DONE holds until new_hand or reset.
- step handling:
  - in CHK1, CHK2 or DONE: ignored, not queued.
  - only one card per strobe; a step held high for k cycles deals one card per cycle in DEAL states.
- done = (state == DONE). Win flags are combinational from the scores and are 0 unless done. A tie sets both flags.
- new_hand (any state):
  - clears all cards, returns to DEAL_P1, deasserts done and the win flags at that edge.
  - does not reset the counter.
  - new_hand has priority over a simultaneous step: no card is dealt.
- Reset mid-hand discards all state immediately, with no completion.
- Undealt third-card registers remain 0, so the downstream display shows blank.

Test Plan:
1. Reset then release; step in cycle 0 -> pcard1=1 next cycle. All other cards 0, pscore=1, dscore=0, done=0.
2. Natural: deal P1=4, D1=2, P2=5, D2=3 -> pscore=9, dscore=5; done=1 after the CHK1 cycle; player_win=1, dealer_win=0; pcard3=dcard3=0. Two further steps change nothing.
3. Banker stands on 3 against an 8: P=2,3; D=K,3; P3=8 -> pscore=3, dscore=3; DONE without a D3 step; tie, so player_win=dealer_win=1.
4. Player stands, dealer draws: P=J,6 (6); D=A,4 (5) -> FSM goes to DEAL_D3. Step deals D3=Q -> dscore=5; done, player_win=1, dealer_win=0.
5. Face cards: P=K,Q (0); D=J,A (1). P3=2 -> pscore=2; dealer draws on 1; D3=9 -> dscore=0; player_win=1.
6. Edge cases:
   - step asserted in the CHK1 cycle -> no card loaded.
   - new_hand and step in the same cycle during DEAL_P2 -> all cards 0, state DEAL_P1, no card dealt.
   - resetb pulsed low mid-cycle during DEAL_D3 -> outputs 0 immediately and counter restarts at 1.

Source files
------------

// File: rtl/card_dealer.sv
// Baccarat hand sequencer: samples a free-running 1..13 counter on each step strobe,
// deals player/dealer cards, applies third-card rules and reports scores and winner.
module card_dealer (
   input  logic       clk,
   input  logic       resetb,
   input  logic       step,
   input  logic       new_hand,
   output logic [3:0] pcard1,
   output logic [3:0] pcard2,
   output logic [3:0] pcard3,
   output logic [3:0] dcard1,
   output logic [3:0] dcard2,
   output logic [3:0] dcard3,
   output logic [3:0] pscore,
   output logic [3:0] dscore,
   output logic       done,
   output logic       player_win,
   output logic       dealer_win
);

   typedef enum logic [3:0] {
      StDealP1, StDealD1, StDealP2, StDealD2, StChk1,
      StDealP3, StChk2, StDealD3, StDone
   } state_t;

   state_t     r_state;
   logic [3:0] r_cnt;
   logic [3:0] r_pcard1, r_pcard2, r_pcard3;
   logic [3:0] r_dcard1, r_dcard2, r_dcard3;
   logic       r_done;

   logic [3:0] w_pscore, w_dscore, w_p3_val;
   logic       w_dealer_draw;
   logic       w_natural;

   function automatic logic [3:0] card_val(input logic [3:0] c);
      return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
   endfunction

   function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c);
      logic [4:0] s;
      logic [4:0] r;
      s = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
      if (s >= 5'd20)      r = s - 5'd20;
      else if (s >= 5'd10) r = s - 5'd10;
      else                 r = s;
      return r[3:0];
   endfunction

   assign w_pscore  = hand_score(r_pcard1, r_pcard2, r_pcard3);
   assign w_dscore  = hand_score(r_dcard1, r_dcard2, r_dcard3);
   assign w_p3_val  = card_val(r_pcard3);
   assign w_natural = (w_pscore >= 4'd8) || (w_dscore >= 4'd8);

   // Banker's draw decision once the player has taken a third card
   always_comb begin
      w_dealer_draw = 1'b0;
      case (w_dscore)
         4'd0, 4'd1, 4'd2: w_dealer_draw = 1'b1;
         4'd3:             w_dealer_draw = (w_p3_val != 4'd8);
         4'd4:             w_dealer_draw = (w_p3_val >= 4'd2) && (w_p3_val <= 4'd7);
         4'd5:             w_dealer_draw = (w_p3_val >= 4'd4) && (w_p3_val <= 4'd7);
         4'd6:             w_dealer_draw = (w_p3_val >= 4'd6) && (w_p3_val <= 4'd7);
         default:          w_dealer_draw = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_state  <= StDealP1;
         r_cnt    <= 4'd1;
         r_pcard1 <= 4'd0;
         r_pcard2 <= 4'd0;
         r_pcard3 <= 4'd0;
         r_dcard1 <= 4'd0;
         r_dcard2 <= 4'd0;
         r_dcard3 <= 4'd0;
         r_done   <= 1'b0;
      end else begin
         r_cnt <= (r_cnt == 4'd13) ? 4'd1 : r_cnt + 4'd1;
         if (new_hand) begin
            r_state  <= StDealP1;
            r_pcard1 <= 4'd0;
            r_pcard2 <= 4'd0;
            r_pcard3 <= 4'd0;
            r_dcard1 <= 4'd0;
            r_dcard2 <= 4'd0;
            r_dcard3 <= 4'd0;
            r_done   <= 1'b0;
         end else begin
            unique case (r_state)
               StDealP1: if (step) begin r_pcard1 <= r_cnt; r_state <= StDealD1; end
               StDealD1: if (step) begin r_dcard1 <= r_cnt; r_state <= StDealP2; end
               StDealP2: if (step) begin r_pcard2 <= r_cnt; r_state <= StDealD2; end
               StDealD2: if (step) begin r_dcard2 <= r_cnt; r_state <= StChk1;   end
               StChk1: begin
                  if (w_natural) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end else if (w_pscore <= 4'd5) begin
                     r_state <= StDealP3;
                  end else if (w_dscore <= 4'd5) begin
                     r_state <= StDealD3;
                  end else begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end
               end
               StDealP3: if (step) begin r_pcard3 <= r_cnt; r_state <= StChk2; end
               StChk2: begin
                  if (w_dealer_draw) begin
                     r_state <= StDealD3;
                  end else begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end
               end
               StDealD3: begin
                  if (step) begin
                     r_dcard3 <= r_cnt;
                     r_state  <= StDone;
                     r_done   <= 1'b1;
                  end
               end
               StDone: ;
               default: begin
                  r_state <= StDealP1;
                  r_done  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pcard1     = r_pcard1;
   assign pcard2     = r_pcard2;
   assign pcard3     = r_pcard3;
   assign dcard1     = r_dcard1;
   assign dcard2     = r_dcard2;
   assign dcard3     = r_dcard3;
   assign pscore     = w_pscore;
   assign dscore     = w_dscore;
   assign done       = r_done;
   assign player_win = r_done && (w_pscore >= w_dscore);
   assign dealer_win = r_done && (w_dscore >= w_pscore);

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: directed hands plus random hands checked against a rule-level model.
module tb_card_dealer;

   logic       clk;
   logic       resetb;
   logic       step;
   logic       new_hand;
   logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
   logic [3:0] pscore, dscore;
   logic       done, player_win, dealer_win;

   int checks;
   int failures;

   // Model: mc[0..2] player cards, mc[3..5] dealer cards; tb_cnt mirrors the deck counter
   int mc[6];
   int tb_cnt;
   bit m_done;

   card_dealer u_dut (
      .clk        (clk),
      .resetb     (resetb),
      .step       (step),
      .new_hand   (new_hand),
      .pcard1     (pcard1),
      .pcard2     (pcard2),
      .pcard3     (pcard3),
      .dcard1     (dcard1),
      .dcard2     (dcard2),
      .dcard3     (dcard3),
      .pscore     (pscore),
      .dscore     (dscore),
      .done       (done),
      .player_win (player_win),
      .dealer_win (dealer_win)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int val(input int c);
      return (c >= 1 && c <= 9) ? c : 0;
   endfunction

   function automatic int pscore_m();
      return (val(mc[0]) + val(mc[1]) + val(mc[2])) % 10;
   endfunction

   function automatic int dscore_m();
      return (val(mc[3]) + val(mc[4]) + val(mc[5])) % 10;
   endfunction

   function automatic bit banker_draws(input int ds, input int v);
      if (ds <= 2) return 1'b1;
      if (ds == 3) return v != 8;
      if (ds == 4) return v >= 2 && v <= 7;
      if (ds == 5) return v >= 4 && v <= 7;
      if (ds == 6) return v >= 6 && v <= 7;
      return 1'b0;
   endfunction

   // Which slot receives the next card under baccarat rules; 6 means the hand is over
   function automatic int next_slot();
      int ps, ds;
      if (mc[0] == 0) return 0;
      if (mc[3] == 0) return 3;
      if (mc[1] == 0) return 1;
      if (mc[4] == 0) return 4;
      ps = (val(mc[0]) + val(mc[1])) % 10;
      ds = (val(mc[3]) + val(mc[4])) % 10;
      if (ps >= 8 || ds >= 8) return 6;
      if (mc[5] != 0) return 6;
      if (mc[2] != 0) return banker_draws(ds, val(mc[2])) ? 5 : 6;
      if (ps <= 5) return 2;
      if (ds <= 5) return 5;
      return 6;
   endfunction

   task automatic chk(input string tag, input string name, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s.%s got=%0d exp=%0d", tag, name, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int ps, ds;
      ps = pscore_m();
      ds = dscore_m();
      chk(tag, "pcard1", {4'd0, pcard1}, 8'(mc[0]));
      chk(tag, "pcard2", {4'd0, pcard2}, 8'(mc[1]));
      chk(tag, "pcard3", {4'd0, pcard3}, 8'(mc[2]));
      chk(tag, "dcard1", {4'd0, dcard1}, 8'(mc[3]));
      chk(tag, "dcard2", {4'd0, dcard2}, 8'(mc[4]));
      chk(tag, "dcard3", {4'd0, dcard3}, 8'(mc[5]));
      chk(tag, "pscore", {4'd0, pscore}, 8'(ps));
      chk(tag, "dscore", {4'd0, dscore}, 8'(ds));
      chk(tag, "done", {7'd0, done}, {7'd0, m_done});
      chk(tag, "player_win", {7'd0, player_win}, {7'd0, m_done && ps >= ds});
      chk(tag, "dealer_win", {7'd0, dealer_win}, {7'd0, m_done && ds >= ps});
   endtask

   task automatic clear_model();
      for (int i = 0; i < 6; i++) mc[i] = 0;
      m_done = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (resetb) tb_cnt = (tb_cnt == 13) ? 1 : tb_cnt + 1;
      else        tb_cnt = 1;
      #1;
   endtask

   task automatic nh();
      new_hand = 1'b1;
      tick();
      new_hand = 1'b0;
      clear_model();
      check_all("new_hand");
   endtask

   // Wait for the counter to show code, strobe step once, then step through any check cycle
   task automatic deal(input int code, input bit chk_step);
      int s;
      int guard;
      s = next_slot();
      chk("deal", "slot_open", {7'd0, s != 6}, 8'd1);
      guard = 0;
      while (tb_cnt != code && guard < 20) begin
         tick();
         guard++;
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      if (s != 6) mc[s] = code;
      m_done = (s == 5);
      check_all("deal");
      if (s == 4 || s == 2) begin
         step = chk_step;
         tick();
         step = 1'b0;
         m_done = (next_slot() == 6);
         check_all("chk");
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      resetb   = 1'b0;
      step     = 1'b0;
      new_hand = 1'b0;
      tb_cnt   = 1;
      clear_model();
      #3;
      check_all("reset");
      tick();
      tick();

      // 1: first step after release deals counter value 1
      resetb = 1'b1;
      step   = 1'b1;
      tick();
      step   = 1'b0;
      mc[0]  = 1;
      check_all("first_deal");

      // 2: player natural 9, extra steps in DONE ignored
      nh();
      deal(4, 1'b0);
      deal(2, 1'b0);
      deal(5, 1'b0);
      deal(3, 1'b0);
      step = 1'b1;
      tick();
      tick();
      step = 1'b0;
      check_all("done_hold");

      // 3: banker stands on 3 against an 8; step in CHK1 ignored
      nh();
      deal(2, 1'b0);
      deal(13, 1'b0);
      deal(3, 1'b0);
      deal(3, 1'b1);
      deal(8, 1'b0);

      // 4: player stands on 6, dealer draws on 5
      nh();
      deal(11, 1'b0);
      deal(1, 1'b0);
      deal(6, 1'b0);
      deal(4, 1'b0);
      deal(12, 1'b0);

      // 5: face cards, both draw
      nh();
      deal(13, 1'b0);
      deal(11, 1'b0);
      deal(12, 1'b0);
      deal(1, 1'b0);
      deal(2, 1'b0);
      deal(9, 1'b0);

      // new_hand beats step during DEAL_P2
      nh();
      deal(7, 1'b0);
      deal(8, 1'b0);
      step     = 1'b1;
      new_hand = 1'b1;
      tick();
      step     = 1'b0;
      new_hand = 1'b0;
      clear_model();
      check_all("nh_vs_step");
      deal(5, 1'b0);

      // Asynchronous reset mid-cycle while waiting in DEAL_D3
      nh();
      deal(11, 1'b0);
      deal(1, 1'b0);
      deal(6, 1'b0);
      deal(4, 1'b0);
      #2;
      resetb = 1'b0;
      #1;
      clear_model();
      tb_cnt = 1;
      check_all("mid_reset");
      tick();
      resetb = 1'b1;
      step   = 1'b1;
      tick();
      step   = 1'b0;
      mc[0]  = 1;
      check_all("reset_counter");

      // Random hands against the rule model
      for (int h = 0; h < 25; h++) begin
         nh();
         for (int k = 0; k < 6 && next_slot() != 6; k++) begin
            deal(int'($urandom_range(13, 1)), 1'($urandom_range(1, 0)));
         end
         step = 1'($urandom_range(1, 0));
         tick();
         step = 1'b0;
         check_all("rand_end");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
